// File: rtl/lstm_seq_ctrl.sv
// Sequencer that steps an external combinational LSTM cell through a sequence.
// Optional cell-state saturation: define LSTM_SEQ_CTRL_CLIP_EN.
module lstm_seq_ctrl #(
    parameter int                            DATA_WIDTH  = 16,
    parameter int                            FRACT_WIDTH = 8,
    parameter int                            LEN_W       = 8,
    parameter int                            SETTLE      = 2,
    parameter logic signed [DATA_WIDTH-1:0]  CLIP        = 16'sh0800
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      seq_len,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [DATA_WIDTH-1:0] cell_c_in,
    output logic [DATA_WIDTH-1:0] cell_h_in,
    input  logic [DATA_WIDTH-1:0] cell_c_out,
    input  logic [DATA_WIDTH-1:0] cell_h_out,
    output logic                  h_valid,
    input  logic                  h_ready,
    output logic [DATA_WIDTH-1:0] h_data,
    output logic                  h_last,
    output logic                  busy,
    output logic                  done
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("lstm_seq_ctrl: SETTLE must be in 1..15");
    end
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
        $error("lstm_seq_ctrl: FRACT_WIDTH must be below DATA_WIDTH");
    end
    if (CLIP < 0) begin : g_bad_clip
        $error("lstm_seq_ctrl: CLIP must be non-negative");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_X,
        ST_SETTLE,
        ST_EMIT,
        ST_FIN
    } state_t;

    state_t state, state_d;

    logic [LEN_W-1:0]             rem_cnt;
    logic [3:0]                   settle_cnt;
    logic [DATA_WIDTH-1:0]        c_state;
    logic [DATA_WIDTH-1:0]        h_state;
    logic [DATA_WIDTH-1:0]        c_capt;
    logic                         accept;
    logic                         x_fire;
    logic                         cap_fire;
    logic                         h_fire;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        x_ready  = 1'b0;
        h_valid  = 1'b0;
        h_last   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        accept   = 1'b0;
        x_fire   = 1'b0;
        cap_fire = 1'b0;
        h_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = (seq_len == '0) ? ST_FIN : ST_WAIT_X;
                end
            end
            ST_WAIT_X: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    x_fire  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    cap_fire = 1'b1;
                    state_d  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                h_valid = 1'b1;
                h_last  = (rem_cnt == LEN_W'(1));
                if (h_ready) begin
                    h_fire  = 1'b1;
                    state_d = (rem_cnt == LEN_W'(1)) ? ST_FIN : ST_WAIT_X;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LSTM_SEQ_CTRL_CLIP_EN
    // Saturate the stored cell state to [-CLIP, +CLIP]; h is passed through.
    always_comb begin
        c_capt = cell_c_out;
        if ($signed(cell_c_out) > CLIP)
            c_capt = CLIP;
        else if ($signed(cell_c_out) < -CLIP)
            c_capt = -CLIP;
    end
`else
    always_comb begin
        c_capt = cell_c_out;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_cnt    <= '0;
            settle_cnt <= '0;
            c_state    <= '0;
            h_state    <= '0;
            cell_x     <= '0;
            cell_c_in  <= '0;
            cell_h_in  <= '0;
            h_data     <= '0;
        end else begin
            if (accept) begin
                rem_cnt <= seq_len;
                c_state <= '0;
                h_state <= '0;
            end
            if (x_fire) begin
                cell_x     <= x_data;
                cell_c_in  <= c_state;
                cell_h_in  <= h_state;
                settle_cnt <= 4'(SETTLE - 1);
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (cap_fire) begin
                c_state <= c_capt;
                h_state <= cell_h_out;
                h_data  <= cell_h_out;
            end
            if (h_fire) begin
                rem_cnt <= rem_cnt - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl with a behavioural sequence model
// and an environment model of the combinational cell.
module tb_lstm_seq_ctrl;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         seq_len;
    logic               x_valid;
    logic               x_ready;
    logic signed [15:0] x_data;
    logic signed [15:0] cell_x;
    logic signed [15:0] cell_c_in;
    logic signed [15:0] cell_h_in;
    logic signed [15:0] cell_c_out;
    logic signed [15:0] cell_h_out;
    logic               h_valid;
    logic               h_ready;
    logic signed [15:0] h_data;
    logic               h_last;
    logic               busy;
    logic               done;

    int tests = 0;
    int fails = 0;

    lstm_seq_ctrl #(
        .DATA_WIDTH (16),
        .FRACT_WIDTH(8),
        .LEN_W      (8),
        .SETTLE     (2),
        .CLIP       (16'sh0800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seq_len   (seq_len),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .cell_x    (cell_x),
        .cell_c_in (cell_c_in),
        .cell_h_in (cell_h_in),
        .cell_c_out(cell_c_out),
        .cell_h_out(cell_h_out),
        .h_valid   (h_valid),
        .h_ready   (h_ready),
        .h_data    (h_data),
        .h_last    (h_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell environment: c_out = c_in + x, h_out = x (or x + h_in/2), or a forced c_out.
    logic               hm_mode  = 1'b0;
    logic               frc_mode = 1'b0;
    logic signed [15:0] frc_val  = '0;
    always_comb begin
        cell_c_out = frc_mode ? frc_val : cell_c_in + cell_x;
        cell_h_out = hm_mode ? cell_x + (cell_h_in >>> 1) : cell_x;
    end

    logic signed [15:0] xs      [256];
    logic signed [15:0] cap_h   [256];
    logic signed [15:0] cap_cin [256];
    logic               cap_last[256];
    int                 hcyc    [256];
    int first_x_cyc, first_hv_cyc, done_cyc;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] exp_cin;
        logic signed [15:0] exp_h;
        logic               exp_last;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] clip_model(input logic signed [15:0] v);
        int iv;
        iv = int'(v);
`ifdef LSTM_SEQ_CTRL_CLIP_EN
        if (iv > 2048)  iv = 2048;
        if (iv < -2048) iv = -2048;
`endif
        return 16'(iv);
    endfunction

    task automatic do_seq(input int len, input int stall_pct, input int hold_first,
                          input bit spur, input bit hm, input bit frc, input logic [15:0] fval);
        logic signed [15:0] ecin[256];
        logic signed [15:0] ehin[256];
        logic signed [15:0] eh  [256];
        logic signed [15:0] c, h, cn;
        int  xi, oi, held, cyc, budget;
        bit  xpend, xv, hr, got_done;
        c = '0;
        h = '0;
        for (int k = 0; k < len; k++) begin
            ecin[k] = c;
            ehin[k] = h;
            cn = frc ? clip_model(fval) : c + xs[k];
            h  = hm ? xs[k] + (h >>> 1) : xs[k];
            c  = cn;
            eh[k] = h;
        end
        hm_mode  = hm;
        frc_mode = frc;
        frc_val  = fval;
        xi = 0; oi = 0; held = 0; xpend = 0; got_done = 0;
        first_x_cyc = -1; first_hv_cyc = -1; done_cyc = -1;
        budget = 40 * len + 40 + hold_first;
        start   = 1'b1;
        seq_len = 8'(len);
        x_valid = 1'b0;
        h_ready = 1'b0;
        @(posedge clk); #1;
        start   = 1'b0;
        seq_len = 8'($urandom_range(0, 255));
        for (cyc = 0; cyc < budget; cyc++) begin
            if (xpend) begin
                chk("cell_x", cell_x, xs[xi-1]);
                chk("cell_c_in", cell_c_in, ecin[xi-1]);
                chk("cell_h_in", cell_h_in, ehin[xi-1]);
                cap_cin[xi-1] = cell_c_in;
                xpend = 0;
            end
            if (done) begin
                done_cyc = cyc;
                got_done = 1;
                break;
            end
            if (h_valid) begin
                if (first_hv_cyc < 0) first_hv_cyc = cyc;
                if (oi >= len) chk("h_valid_excess", 16'(h_valid), 16'h0);
                else begin
                    chk("h_data", h_data, eh[oi]);
                    chk("h_last", 16'(h_last), 16'(oi == len - 1));
                    chk("x_ready_in_emit", 16'(x_ready), 16'h0);
                end
            end
            xv = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            hr = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            if (h_valid && oi == 0 && held < hold_first) begin
                hr = 0;
                held++;
            end
            x_valid = xv;
            x_data  = (xi < len) ? xs[xi] : 16'sh0;
            h_ready = hr;
            start   = spur && x_ready && xi == 0 && xv;
            if (start) seq_len = 8'd7;
            if (x_ready && xv) begin
                if (xi >= len) chk("x_ready_excess", 16'(x_ready), 16'h0);
                else begin
                    if (first_x_cyc < 0) first_x_cyc = cyc;
                    xpend = 1;
                    xi++;
                end
            end
            if (h_valid && hr && oi < len) begin
                cap_h[oi]    = h_data;
                cap_last[oi] = h_last;
                hcyc[oi]     = cyc;
                oi++;
            end
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        h_ready = 1'b0;
        start   = 1'b0;
        chk("done_seen", 16'(got_done), 16'h1);
        chk("outputs", 16'(oi), 16'(len));
        if (hold_first > 0) chk("held_cycles", 16'(held), 16'(hold_first));
        @(posedge clk); #1;
        chk("done_one_cycle", 16'(done), 16'h0);
        chk("idle_busy", 16'(busy), 16'h0);
    endtask

    initial begin
        int nx;
        bit bad;
        rst = 1'b1; start = 1'b0; seq_len = '0;
        x_valid = 1'b0; x_data = '0; h_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_x_ready", 16'(x_ready), 16'h0);
        chk("rst_h_valid", 16'(h_valid), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_h_data", h_data, 16'h0);
        chk("rst_cell_c_in", cell_c_in, 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 3-step run against fixed vectors
        tbl[0] = '{16'sh0100, 16'sh0000, 16'sh0100, 1'b0};
        tbl[1] = '{16'sh0200, 16'sh0100, 16'sh0200, 1'b0};
        tbl[2] = '{16'sh0300, 16'sh0300, 16'sh0300, 1'b1};
        for (int i = 0; i < 3; i++) xs[i] = tbl[i].x;
        do_seq(3, 0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("tbl_cin", cap_cin[i], tbl[i].exp_cin);
            chk("tbl_h", cap_h[i], tbl[i].exp_h);
            chk("tbl_last", 16'(cap_last[i]), 16'(tbl[i].exp_last));
        end
        chk("latency", 16'(first_hv_cyc - first_x_cyc), 16'd3);
        chk("spacing01", 16'(hcyc[1] - hcyc[0]), 16'd4);
        chk("spacing12", 16'(hcyc[2] - hcyc[1]), 16'd4);
        chk("done_after_last", 16'(done_cyc - hcyc[2]), 16'd1);

        // Zero length
        do_seq(0, 0, 0, 0, 0, 0, 16'h0);
        chk("zero_done_time", 16'(done_cyc <= 1), 16'h1);

        // Backpressure on first output
        for (int i = 0; i < 2; i++) xs[i] = 16'($urandom);
        do_seq(2, 0, 5, 0, 1, 0, 16'h0);

        // Start pulsed mid-run is ignored
        for (int i = 0; i < 2; i++) xs[i] = 16'($urandom);
        do_seq(2, 0, 0, 1, 1, 0, 16'h0);
        chk("spur_outputs", 16'(hcyc[1] > hcyc[0]), 16'h1);

        // Randomised runs with stalls
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) xs[i] = 16'($urandom);
            do_seq(len, 30, 0, 0, 1, 0, 16'h0);
        end

        // Maximum length, no wrap
        for (int i = 0; i < 255; i++) xs[i] = 16'($urandom);
        do_seq(255, 0, 0, 0, 1, 0, 16'h0);
        chk("max_last_only_end", 16'(cap_last[253]), 16'h0);

        // Cell-state capture with large c_out values
        xs[0] = '0; xs[1] = '0;
        do_seq(2, 0, 0, 0, 0, 1, 16'h7F00);
`ifdef LSTM_SEQ_CTRL_CLIP_EN
        chk("clip_pos", cap_cin[1], 16'h0800);
`else
        chk("clip_pos", cap_cin[1], 16'h7F00);
`endif
        do_seq(2, 0, 0, 0, 0, 1, 16'h8100);
`ifdef LSTM_SEQ_CTRL_CLIP_EN
        chk("clip_neg", cap_cin[1], 16'hF800);
`else
        chk("clip_neg", cap_cin[1], 16'h8100);
`endif
        frc_mode = 1'b0;
        hm_mode  = 1'b0;

        // Reset during SETTLE of step 2 of a 4-step run
        start = 1'b1; seq_len = 8'd4; x_valid = 1'b1; x_data = 16'sh0100; h_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nx = 0;
        for (int i = 0; i < 40 && nx < 2; i++) begin
            if (x_ready) nx++;
            if (nx < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("reset_setup", 16'(nx), 16'd2);
        @(posedge clk); #1;
        chk("cin_pre_rst", cell_c_in, 16'h0100);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_x_ready", 16'(x_ready), 16'h0);
        chk("mid_rst_h_valid", 16'(h_valid), 16'h0);
        chk("mid_rst_h_last", 16'(h_last), 16'h0);
        chk("mid_rst_done", 16'(done), 16'h0);
        chk("mid_rst_cell_c_in", cell_c_in, 16'h0);
        chk("mid_rst_cell_x", cell_x, 16'h0);
        chk("mid_rst_cell_h_in", cell_h_in, 16'h0);
        chk("mid_rst_h_data", h_data, 16'h0);
        rst = 1'b0;
        x_valid = 1'b0;
        h_ready = 1'b0;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) bad = 1;
        end
        chk("no_done_after_rst", 16'(bad), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
